// File: rtl/lzc_word_feeder.sv
// Serialises one WIDTH*WORD-bit vector into WORD beats for the LZC, then waits
// for its OVALID (bounded by a watchdog) before accepting the next vector.
module lzc_word_feeder #(
    parameter int WIDTH   = 8,
    parameter int WORD    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [WIDTH*WORD-1:0]   IN_DATA,
    input  logic                    IN_MODE,
    output logic                    IVALID,
    output logic [WIDTH-1:0]        DATA,
    output logic                    MODE,
    input  logic                    OVALID,
    output logic                    BUSY,
    output logic                    TO_ERR
);

    localparam int VW = WIDTH * WORD;
    localparam int CW = (WORD > 1) ? $clog2(WORD) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [VW-1:0]   shift_q, shift_d;
    logic            mode_q, mode_d;
    logic            ivalid_q, ivalid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic            busy_q, busy_d;
    logic            to_err_q, to_err_d;

    // State and registered outputs; reset drops any in-flight vector at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            timer_q  <= '0;
            shift_q  <= '0;
            mode_q   <= 1'b0;
            ivalid_q <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            shift_q  <= shift_d;
            mode_q   <= mode_d;
            ivalid_q <= ivalid_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            to_err_q <= to_err_d;
        end
    end

    // Next-state logic; OVALID takes priority over the watchdog in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) state_d = ST_SEND;
                else          state_d = ST_IDLE;
            end
            ST_SEND: begin
                if (cnt_q == CNT_LAST) state_d = ST_WAIT;
                else                   state_d = ST_SEND;
            end
            ST_WAIT: begin
                if (OVALID)                 state_d = ST_IDLE;
                else if (timer_q == TMR_LAST) state_d = ST_IDLE;
                else                        state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        shift_d  = shift_q;
        mode_d   = mode_q;
        ivalid_d = 1'b0;
        data_d   = '0;
        to_err_d = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                timer_d = '0;
                if (IN_VALID) begin
                    // Beat 0 goes straight to DATA; the rest queue up in the shifter.
                    data_d   = IN_DATA[VW-1 -: WIDTH];
                    shift_d  = IN_DATA << WIDTH;
                    ivalid_d = 1'b1;
                    mode_d   = IN_MODE;
                end else begin
                    mode_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (cnt_q == CNT_LAST) begin
                    timer_d = '0;
                end else begin
                    ivalid_d = 1'b1;
                    data_d   = shift_q[VW-1 -: WIDTH];
                    shift_d  = shift_q << WIDTH;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            ST_WAIT: begin
                if (OVALID) begin
                    mode_d = 1'b0;
                end else if (timer_q == TMR_LAST) begin
                    mode_d   = 1'b0;
                    to_err_d = 1'b1;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            default: begin
                mode_d = 1'b0;
            end
        endcase
    end

    assign IN_READY = (state_q == ST_IDLE);
    assign IVALID   = ivalid_q;
    assign DATA     = data_q;
    assign MODE     = mode_q;
    assign BUSY     = busy_q;
    assign TO_ERR   = to_err_q;

endmodule

// File: tb/tb_lzc_word_feeder.sv
// Self-checking bench for lzc_word_feeder (WIDTH=8, WORD=4, TIMEOUT=8):
// directed table, hand sequences, and random traffic against a queue model.
module tb_lzc_word_feeder;

    localparam int WIDTH   = 8;
    localparam int WORD    = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_mode = 1'b0;
    logic        ivalid;
    logic [7:0]  data_o;
    logic        mode_o;
    logic        ovalid = 1'b0;
    logic        busy;
    logic        to_err;

    int checks = 0;
    int failures = 0;

    lzc_word_feeder #(.WIDTH(WIDTH), .WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_DATA(in_data), .IN_MODE(in_mode), .IVALID(ivalid), .DATA(data_o),
        .MODE(mode_o), .OVALID(ovalid), .BUSY(busy), .TO_ERR(to_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: a queue of pending beats plus a WAIT-cycle count.
    logic [7:0] q[$];
    bit         m_busy = 1'b0;
    bit         m_mode = 1'b0;
    bit         m_err  = 1'b0;
    int         m_wait = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_busy = 1'b0; m_mode = 1'b0; m_err = 1'b0; m_wait = 0;
        end else begin
            m_err = 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    for (int k = 0; k < WORD; k++) q.push_back(in_data[31 - 8*k -: 8]);
                    m_mode = in_mode;
                    m_busy = 1'b1;
                    m_wait = 0;
                end
            end else if (q.size() > 0) begin
                void'(q.pop_front());
                m_wait = 0;
            end else if (ovalid) begin
                m_busy = 1'b0; m_mode = 1'b0;
            end else if (m_wait == TIMEOUT - 1) begin
                m_busy = 1'b0; m_mode = 1'b0; m_err = 1'b1;
            end else begin
                m_wait++;
            end
        end
    end

    always @(negedge clk) begin
        check("m_ivalid", {31'd0, ivalid}, {31'd0, q.size() > 0});
        check("m_data", {24'd0, data_o}, (q.size() > 0) ? {24'd0, q[0]} : 32'd0);
        check("m_mode", {31'd0, mode_o}, {31'd0, m_busy & m_mode});
        check("m_busy", {31'd0, busy}, {31'd0, m_busy});
        check("m_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        check("m_to_err", {31'd0, to_err}, {31'd0, m_err});
    end

    // One transaction; returns observed beats, WAIT length and whether TO_ERR fired.
    task automatic run_txn(input logic [31:0] d, input logic m, input bit ov_send,
                           input int ov_at, input bit bp,
                           output logic [31:0] beats, output int waits, output bit err);
        int guard;
        int end_w;
        beats = 32'h0; waits = 0; err = 1'b0; guard = 0;
        end_w = (ov_at < TIMEOUT) ? ov_at : TIMEOUT - 1;
        while (!in_ready && guard < 40) begin tick(); guard++; end
        check("ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d; in_mode = m;
        tick();
        for (int c = 0; c < WORD; c++) begin
            beats = {beats[23:0], (ivalid ? data_o : 8'h00)};
            in_valid = bp; in_data = $urandom; in_mode = 1'($urandom);
            ovalid = ov_send && (c == 1);
            tick();
        end
        ovalid = 1'b0;
        while (busy && waits < 20) begin
            ovalid   = (waits == ov_at);
            in_valid = bp && (waits < end_w);
            tick();
            waits++;
            if (to_err) err = 1'b1;
        end
        ovalid = 1'b0; in_valid = 1'b0;
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] d;
        logic        m;
        bit          ov_send;
        int          ov_at;
        bit          bp;
        logic [31:0] exp_beats;
        int          exp_waits;
        bit          exp_err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [31:0] beats;
        int          waits;
        bit          err;
        int          guard;

        tbl[0] = '{32'h0001_80FF, 1'b1, 1'b0, 2,  1'b0, 32'h0001_80FF, 3, 1'b0};
        tbl[1] = '{32'hFFFF_0000, 1'b0, 1'b0, 99, 1'b0, 32'hFFFF_0000, 8, 1'b1};
        tbl[2] = '{32'hA5C3_3C5A, 1'b1, 1'b1, 0,  1'b1, 32'hA5C3_3C5A, 1, 1'b0};
        tbl[3] = '{32'h1234_5678, 1'b0, 1'b0, 7,  1'b1, 32'h1234_5678, 8, 1'b0};
        tbl[4] = '{32'h8000_0001, 1'b1, 1'b1, 5,  1'b0, 32'h8000_0001, 6, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_ivalid", {31'd0, ivalid}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_mode", {31'd0, mode_o}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_to_err", {31'd0, to_err}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].d, tbl[i].m, tbl[i].ov_send, tbl[i].ov_at, tbl[i].bp, beats, waits, err);
            check("tbl_beats", beats, tbl[i].exp_beats);
            check("tbl_waits", waits, tbl[i].exp_waits);
            check("tbl_err", {31'd0, err}, {31'd0, tbl[i].exp_err});
            tick();
        end

        // Completion followed by an immediate back-to-back accept of a held vector.
        in_valid = 1'b1; in_data = 32'h0001_80FF; in_mode = 1'b1;
        tick();
        in_data = 32'hFFFF_0000; in_mode = 1'b0;
        repeat (WORD) tick();
        for (int w = 0; w < 3; w++) begin
            ovalid = (w == 2);
            tick();
        end
        ovalid = 1'b0;
        check("b2b_ready", {31'd0, in_ready}, 32'd1);
        check("b2b_no_err", {31'd0, to_err}, 32'd0);
        tick();
        check("b2b_ivalid", {31'd0, ivalid}, 32'd1);
        check("b2b_beat0", {24'd0, data_o}, 32'h0000_00FF);
        check("b2b_mode", {31'd0, mode_o}, 32'd0);
        in_valid = 1'b0;
        tick();
        check("b2b_beat1", {24'd0, data_o}, 32'h0000_00FF);
        tick();
        check("b2b_beat2", {24'd0, data_o}, 32'h0000_0000);
        guard = 0;
        while (busy && guard < 30) begin tick(); guard++; end
        check("b2b_drain", {31'd0, busy}, 32'd0);
        tick();

        // Reset during beat 2 must discard the vector immediately.
        in_valid = 1'b1; in_data = 32'hCAFE_BABE; in_mode = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("rst_mid_beat2", {24'd0, data_o}, 32'h0000_00BA);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ivalid", {31'd0, ivalid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rst_mid_nobeat", {31'd0, ivalid}, 32'd0);
        end

        // Random traffic; the model checker compares every cycle.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] d;
            logic        m;
            int          ov_at;
            d = $urandom; m = 1'($urandom); ov_at = $urandom_range(0, 10);
            run_txn(d, m, 1'($urandom), ov_at, 1'($urandom), beats, waits, err);
            check("rnd_beats", beats, d);
            check("rnd_waits", waits, (ov_at < TIMEOUT) ? ov_at + 1 : TIMEOUT);
            check("rnd_err", {31'd0, err}, {31'd0, ov_at >= TIMEOUT});
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                ovalid = 1'($urandom);
                tick();
            end
            ovalid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lzc_word_feeder.md
Name: lzc_word_feeder

Overview:
Upstream stage of the LZC block. It accepts one full WIDTH*WORD-bit vector plus a mode bit over a valid/ready handshake. It serialises the vector into WORD consecutive WIDTH-bit beats on the LZC's IVALID/DATA/MODE inputs, then waits for the LZC's OVALID before accepting the next vector. A watchdog aborts the wait if OVALID never arrives.

Parameters:
WIDTH, 8, bits per beat (matches LZC DATA width)
WORD, 16, beats per vector (≥1)
TIMEOUT, 64, max cycles spent in WAIT before abort (≥1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
IN_VALID  in  1  upstream vector valid
IN_READY  out  1  feeder can accept a vector
IN_DATA  in  WIDTH*WORD  vector; bits [WIDTH*WORD-1 -: WIDTH] form beat 0
IN_MODE  in  1  mode bit forwarded to LZC
IVALID  out  1  beat valid to LZC
DATA  out  WIDTH  beat data to LZC
MODE  out  1  mode to LZC
OVALID  in  1  LZC result valid
BUSY  out  1  high when state ≠ IDLE
TO_ERR  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: IVALID=0, DATA=0, MODE=0, BUSY=0, TO_ERR=0, state=IDLE, beat counter=0, timer=0.
- IN_READY is combinational: 1 exactly when state=IDLE, so it reads 1 during reset.
- FSM states: IDLE, SEND, WAIT.
- IDLE: on a rising edge with IN_VALID=1, the feeder latches IN_DATA into a shift register and IN_MODE into a mode register, then moves to SEND.
- SEND:
  - Beat i (i=0..WORD-1) is driven on the i-th cycle after acceptance, most-significant word first.
  - IVALID=1 for exactly WORD consecutive cycles, with no bubbles.
  - MODE equals the latched mode from acceptance until the return to IDLE.
  - After the last beat the FSM moves to WAIT; IVALID=0 and DATA=0 from then on.
- DATA is 0 whenever IVALID=0. MODE is 0 in IDLE.
- WAIT:
  - The timer counts cycles in WAIT, starting at 0.
  - OVALID=1 → IDLE on the next edge; no error.
  - Timer reaching TIMEOUT-1 without OVALID → TO_ERR=1 for exactly one cycle, then IDLE.
  - OVALID and timeout in the same cycle: OVALID wins, TO_ERR stays 0.
- OVALID seen in IDLE or SEND is ignored and has no side effects.
- IN_VALID during SEND/WAIT is ignored (IN_READY=0). IN_DATA must be held until the handshake, which is the upstream's responsibility.
- Throughput: one vector per WORD + 1 + (WAIT duration) cycles minimum. A back-to-back accept is possible on the edge after returning to IDLE.
- Counter widths: beat counter is $clog2(WORD) bits (min 1); timer is $clog2(TIMEOUT) bits (min 1). The timer saturates and never wraps.
- Reset mid-operation: all state clears immediately and the in-flight vector is discarded. No residual beats appear after RST_N releases.
- BUSY and TO_ERR are registered outputs; IN_READY is the only combinational output.

Test Plan:
(All with WIDTH=8, WORD=4, TIMEOUT=8.)
1. Reset: hold RST_N=0 → IVALID=0, DATA=0, MODE=0, BUSY=0, TO_ERR=0, IN_READY=1.
2. Serialise: accept IN_DATA=32'h00_01_80_FF with IN_MODE=1 → next 4 cycles give IVALID=1, DATA=00,01,80,FF, MODE=1. Then IVALID=0, DATA=0, BUSY=1, IN_READY=0.
3. Completion: OVALID pulse on the 3rd WAIT cycle → IN_READY=1 on the following cycle, TO_ERR never asserts. A second vector 32'hFFFF_0000 (mode 0) held valid is accepted immediately and serialises as FF,FF,00,00 with MODE=0.
4. Watchdog: OVALID never asserted → TO_ERR=1 for exactly one cycle, 8 cycles after entering WAIT. Next cycle IN_READY=1 and BUSY=0.
5. Back-pressure and stray signals:
   - IN_VALID held high with changing IN_DATA during SEND → no beats of the second value appear.
   - OVALID pulsed during SEND → ignored, WAIT still entered.
   - OVALID and timeout coincide → no TO_ERR.
6. Mid-operation reset: assert RST_N=0 during beat 2 → IVALID=0 asynchronously. After release: IN_READY=1, BUSY=0, no remaining beats emitted.
